// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: state codes, opcodes,
// ALUop codes (also used by alu_control), ALU operand-B and PC-source selects.
package mips_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned STATE_W  = 4;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC    = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEXEC = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11,
        S_TRAP    = 4'd12
    } state_e;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OPCODE_W-1:0] OP_SLTI  = 6'b001010;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALUOP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALUOP_W-1:0] ALU_RTYPE = 3'b010;
    localparam logic [ALUOP_W-1:0] ALU_AND   = 3'b011;
    localparam logic [ALUOP_W-1:0] ALU_OR    = 3'b100;
    localparam logic [ALUOP_W-1:0] ALU_SLT   = 3'b101;

    localparam logic [SEL_W-1:0] SRCB_REG    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR   = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM    = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // ALU operation for an immediate-format instruction; addi is the fallback.
    function automatic logic [ALUOP_W-1:0] imm_aluop(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_ANDI: imm_aluop = ALU_AND;
            OP_ORI:  imm_aluop = ALU_OR;
            OP_SLTI: imm_aluop = ALU_SLT;
            default: imm_aluop = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Pure state-to-controls decoder for the multicycle control FSM (Moore).
// Ports: state_i (current state), op_i (opcode latched in DECODE), zero_i (ALU
// zero flag, only gates pc_en in BRANCH); outputs are the datapath controls.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_e               state_i,
    input  logic [OPCODE_W-1:0]  op_i,
    input  logic                 zero_i,
    output logic                 pc_en_o,
    output logic                 iord_o,
    output logic                 mem_read_o,
    output logic                 mem_write_o,
    output logic                 ir_write_o,
    output logic                 reg_dst_o,
    output logic                 mem_to_reg_o,
    output logic                 reg_write_o,
    output logic                 alu_src_a_o,
    output logic [SEL_W-1:0]     alu_src_b_o,
    output logic [ALUOP_W-1:0]   aluop_o,
    output logic [SEL_W-1:0]     pc_src_o,
    output logic                 illegal_o
);

    // Every control defaults to 0; each state raises only its own.
    always_comb begin
        pc_en_o      = 1'b0;
        iord_o       = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        ir_write_o   = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write_o  = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_REG;
        aluop_o      = ALU_ADD;
        pc_src_o     = PCSRC_ALU;
        illegal_o    = 1'b0;
        case (state_i)
            S_FETCH: begin
                mem_read_o  = 1'b1;
                ir_write_o  = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                pc_en_o     = 1'b1;
            end
            S_DECODE:  alu_src_b_o = SRCB_IMMSH2;
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
            end
            S_MEMWB: begin
                reg_write_o  = 1'b1;
                mem_to_reg_o = 1'b1;
            end
            S_MEMWR: begin
                mem_write_o = 1'b1;
                iord_o      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_o = 1'b1;
                aluop_o     = ALU_RTYPE;
            end
            S_ALUWB: begin
                reg_write_o = 1'b1;
                reg_dst_o   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_o = 1'b1;
                aluop_o     = ALU_SUB;
                pc_src_o    = PCSRC_ALUOUT;
                pc_en_o     = zero_i;
            end
            S_IMMEXEC: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                aluop_o     = imm_aluop(op_i);
            end
            S_IMMWB:   reg_write_o = 1'b1;
            S_JUMP: begin
                pc_src_o = PCSRC_JUMP;
                pc_en_o  = 1'b1;
            end
            S_TRAP:    illegal_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM plus opcode latch; controls are
// decoded from the registered state by mc_output_decode.
// Ports: clk, reset (sync, active-high), opcode (sampled in DECODE), zero (used
// in BRANCH); memory/datapath controls, ALUop, pc_src, state_o, illegal.
// Parameter ILLEGAL_TRAP: 1 = unknown opcode traps, 0 = treated as NOP.
// Macro MC_IMM_ALU_EN: when defined, andi/ori/slti are decoded; otherwise they
// are unknown opcodes (addi is always supported).
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int ILLEGAL_TRAP = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [OPCODE_W-1:0]  opcode,
    input  logic                 zero,
    output logic                 pc_en,
    output logic                 iord,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 ir_write,
    output logic                 reg_dst,
    output logic                 mem_to_reg,
    output logic                 reg_write,
    output logic                 alu_src_a,
    output logic [SEL_W-1:0]     alu_src_b,
    output logic [ALUOP_W-1:0]   ALUop,
    output logic [SEL_W-1:0]     pc_src,
    output logic [STATE_W-1:0]   state_o,
    output logic                 illegal
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;

    // State and opcode latch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next-state logic; the opcode is captured only while in DECODE
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_IMMEXEC;
`ifdef MC_IMM_ALU_EN
                    OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEXEC;
`endif
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = (ILLEGAL_TRAP != 0) ? S_TRAP : S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = S_FETCH;
            S_EXEC:    state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_IMMEXEC: state_d = S_IMMWB;
            S_IMMWB:   state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
    end

    assign state_o = STATE_W'(state_q);

    mc_output_decode u_dec (
        .state_i      (state_q),
        .op_i         (op_q),
        .zero_i       (zero),
        .pc_en_o      (pc_en),
        .iord_o       (iord),
        .mem_read_o   (mem_read),
        .mem_write_o  (mem_write),
        .ir_write_o   (ir_write),
        .reg_dst_o    (reg_dst),
        .mem_to_reg_o (mem_to_reg),
        .reg_write_o  (reg_write),
        .alu_src_a_o  (alu_src_a),
        .alu_src_b_o  (alu_src_b),
        .aluop_o      (ALUop),
        .pc_src_o     (pc_src),
        .illegal_o    (illegal)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: two instances (ILLEGAL_TRAP=1 and 0) share
// stimulus; a vector table plus directed sequences for traps and resets.
module tb_multicycle_control;
    import mips_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;

    logic t_pc_en, t_iord, t_mr, t_mw, t_irw, t_rdst, t_m2r, t_rw, t_sa, t_ill;
    logic [1:0] t_sb, t_ps;
    logic [2:0] t_aop;
    logic [3:0] t_st;
    logic n_pc_en, n_iord, n_mr, n_mw, n_irw, n_rdst, n_m2r, n_rw, n_sa, n_ill;
    logic [1:0] n_sb, n_ps;
    logic [2:0] n_aop;
    logic [3:0] n_st;

    multicycle_control #(.ILLEGAL_TRAP(1)) u_t (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .pc_en(t_pc_en), .iord(t_iord), .mem_read(t_mr), .mem_write(t_mw),
        .ir_write(t_irw), .reg_dst(t_rdst), .mem_to_reg(t_m2r), .reg_write(t_rw),
        .alu_src_a(t_sa), .alu_src_b(t_sb), .ALUop(t_aop), .pc_src(t_ps),
        .state_o(t_st), .illegal(t_ill)
    );

    multicycle_control #(.ILLEGAL_TRAP(0)) u_n (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
        .pc_en(n_pc_en), .iord(n_iord), .mem_read(n_mr), .mem_write(n_mw),
        .ir_write(n_irw), .reg_dst(n_rdst), .mem_to_reg(n_m2r), .reg_write(n_rw),
        .alu_src_a(n_sa), .alu_src_b(n_sb), .ALUop(n_aop), .pc_src(n_ps),
        .state_o(n_st), .illegal(n_ill)
    );

    logic [20:0] t_vec, n_vec;
    assign t_vec = {t_pc_en, t_iord, t_mr, t_mw, t_irw, t_rdst, t_m2r, t_rw,
                    t_sa, t_sb, t_aop, t_ps, t_st, t_ill};
    assign n_vec = {n_pc_en, n_iord, n_mr, n_mw, n_irw, n_rdst, n_m2r, n_rw,
                    n_sa, n_sb, n_aop, n_ps, n_st, n_ill};

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [20:0] exp_q[$];

    typedef struct packed {
        logic [5:0]  op;
        logic        z;
        logic [3:0]  len;
        logic [19:0] seq;   // state nibbles, first state in [19:16]
    } vec_t;

    vec_t tbl[$];

    // Expected controls for a state, written from the control table
    function automatic logic [20:0] exp_vec(input logic [3:0] st, input logic [5:0] op,
                                            input logic z);
        logic pe, io, mr, mw, irw, rd, m2r, rw, sa, il;
        logic [1:0] sb, ps;
        logic [2:0] ao;
        {pe, io, mr, mw, irw, rd, m2r, rw, sa, il} = '0;
        sb = 2'b00; ps = 2'b00; ao = 3'b000;
        case (st)
            4'd0:  begin mr = 1; irw = 1; sb = 2'b01; pe = 1; end
            4'd1:  sb = 2'b11;
            4'd2:  begin sa = 1; sb = 2'b10; end
            4'd3:  begin mr = 1; io = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mw = 1; io = 1; end
            4'd6:  begin sa = 1; ao = 3'b010; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin sa = 1; ao = 3'b001; ps = 2'b01; pe = z; end
            4'd9: begin
                sa = 1; sb = 2'b10;
                if (op == 6'b001100) ao = 3'b011;
                else if (op == 6'b001101) ao = 3'b100;
                else if (op == 6'b001010) ao = 3'b101;
                else ao = 3'b000;
            end
            4'd10: rw = 1;
            4'd11: begin ps = 2'b10; pe = 1; end
            4'd12: il = 1;
            default: ;
        endcase
        return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, st, il};
    endfunction

    task automatic chk(input string nm, input logic [20:0] got, input logic [20:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (state got=%0d exp=%0d)",
                     nm, got, exp, got[4:1], exp[4:1]);
        end
    endtask

    // One cycle: drive inputs, queue expectations, sample #1 later, advance
    task automatic cyc(input string nm, input logic [5:0] drv_op, input logic z,
                       input logic [3:0] st_t, input logic [5:0] mop,
                       input bit do_n, input logic [3:0] st_n);
        opcode = drv_op;
        zero   = z;
        exp_q.push_back(exp_vec(st_t, mop, z));
        if (do_n) exp_q.push_back(exp_vec(st_n, mop, z));
        #1;
        chk({nm, ".t"}, t_vec, exp_q.pop_front());
        if (do_n) chk({nm, ".n"}, n_vec, exp_q.pop_front());
        @(negedge clk);
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        reset = 1'b1; opcode = 6'b0; zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk({nm, ".t"}, t_vec, exp_vec(4'd0, 6'b0, 1'b0));
        chk({nm, ".n"}, n_vec, exp_vec(4'd0, 6'b0, 1'b0));
    endtask

    initial begin
        vec_t r;
        logic [3:0] st;
        reset = 1'b1; opcode = 6'b0; zero = 1'b0;

        tbl.push_back('{op: 6'b100011, z: 1'b0, len: 4'd5, seq: 20'h01234}); // lw
        tbl.push_back('{op: 6'b101011, z: 1'b0, len: 4'd4, seq: 20'h01250}); // sw
        tbl.push_back('{op: 6'b000000, z: 1'b0, len: 4'd4, seq: 20'h01670}); // R-type
        tbl.push_back('{op: 6'b000100, z: 1'b1, len: 4'd3, seq: 20'h01800}); // beq taken
        tbl.push_back('{op: 6'b000100, z: 1'b0, len: 4'd3, seq: 20'h01800}); // beq not taken
        tbl.push_back('{op: 6'b001000, z: 1'b0, len: 4'd4, seq: 20'h019A0}); // addi
        tbl.push_back('{op: 6'b000010, z: 1'b0, len: 4'd3, seq: 20'h01B00}); // j
`ifdef MC_IMM_ALU_EN
        tbl.push_back('{op: 6'b001100, z: 1'b0, len: 4'd4, seq: 20'h019A0}); // andi
        tbl.push_back('{op: 6'b001101, z: 1'b0, len: 4'd4, seq: 20'h019A0}); // ori
        tbl.push_back('{op: 6'b001010, z: 1'b0, len: 4'd4, seq: 20'h019A0}); // slti
`endif

        do_reset("reset0");

        // Opcode is driven only in DECODE; other cycles carry its complement
        for (int i = 0; i < tbl.size(); i++) begin
            r = tbl[i];
            for (int k = 0; k < int'(r.len); k++) begin
                st = r.seq[19 - 4*k -: 4];
                cyc($sformatf("vec%0d.c%0d", i, k), (st == 4'd1) ? r.op : ~r.op,
                    r.z, st, r.op, 1'b1, st);
            end
        end
        cyc("tail_fetch", 6'b0, 1'b0, 4'd0, 6'b0, 1'b1, 4'd0);

        // Unknown opcode: instance with trap holds in TRAP, the other returns to FETCH
        do_reset("reset1");
        cyc("ill.c0", 6'h3f, 1'b0, 4'd0,  6'h3f, 1'b1, 4'd0);
        cyc("ill.c1", 6'h3f, 1'b0, 4'd1,  6'h3f, 1'b1, 4'd1);
        cyc("ill.c2", 6'h3f, 1'b0, 4'd12, 6'h3f, 1'b1, 4'd0);
        cyc("ill.c3", 6'h3f, 1'b0, 4'd12, 6'h3f, 1'b0, 4'd0);
        cyc("ill.c4", 6'h00, 1'b1, 4'd12, 6'h00, 1'b0, 4'd0);
        do_reset("reset_from_trap");

`ifndef MC_IMM_ALU_EN
        // ori without immediate-ALU support is an unknown opcode
        cyc("ori_off.c0", 6'b001101, 1'b0, 4'd0,  6'b001101, 1'b1, 4'd0);
        cyc("ori_off.c1", 6'b001101, 1'b0, 4'd1,  6'b001101, 1'b1, 4'd1);
        cyc("ori_off.c2", 6'b001101, 1'b0, 4'd12, 6'b001101, 1'b1, 4'd0);
        do_reset("reset2");
`endif

        // Reset in MEMWR: back to FETCH with no further mem_write
        cyc("swrst.c0", 6'b010100, 1'b0, 4'd0, 6'b101011, 1'b1, 4'd0);
        cyc("swrst.c1", 6'b101011, 1'b0, 4'd1, 6'b101011, 1'b1, 4'd1);
        cyc("swrst.c2", 6'b010100, 1'b0, 4'd2, 6'b101011, 1'b1, 4'd2);
        reset = 1'b1;
        cyc("swrst.c3", 6'b010100, 1'b0, 4'd5, 6'b101011, 1'b1, 4'd5);
        reset = 1'b0;
        cyc("swrst.c4", 6'b000000, 1'b0, 4'd0, 6'b000000, 1'b1, 4'd0);
        cyc("swrst.c5", 6'b000000, 1'b0, 4'd1, 6'b000000, 1'b1, 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
